// File: rtl/dm_cache_ctrl_if.sv
// Core-side and memory-side bus of the direct-mapped cache controller.
// The slave modport is the cache's view; the master modport is the
// environment (core + memory) driving requests and memory responses.
interface dm_cache_ctrl_if;
  logic        iReq;
  logic        iWe;
  logic [31:0] iAddr;
  logic [31:0] iWdata;
  logic [3:0]  iBe;
  logic        iFlush;
  logic [31:0] oRdata;
  logic        oStall;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWdata;
  logic [3:0]  oMemBe;
  logic        iMemAck;
  logic [31:0] iMemRdata;

  modport slave (
    input  iReq, iWe, iAddr, iWdata, iBe, iFlush, iMemAck, iMemRdata,
    output oRdata, oStall, oMemReq, oMemWe, oMemAddr, oMemWdata, oMemBe
  );

  modport master (
    output iReq, iWe, iAddr, iWdata, iBe, iFlush, iMemAck, iMemRdata,
    input  oRdata, oStall, oMemReq, oMemWe, oMemAddr, oMemWdata, oMemBe
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller.
// Loads that hit return data combinationally in the request cycle; misses
// refill the whole line word by word; stores always go to memory and update
// the cached copy only when the line is already present.
module dm_cache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic            iCLK,
  input  logic            iRST,
  dm_cache_ctrl_if.slave  bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int OB       = $clog2(LINE_WORDS);
  localparam int CW       = (OB == 0) ? 1 : OB;
  localparam int TAG_BITS = 32 - 2 - OB - INDEX_BITS;
  localparam int AW       = INDEX_BITS + OB;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  // Line index field of a byte address.
  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [31:0] a);
    return INDEX_BITS'(a >> (2 + OB));
  endfunction

  // Tag field of a byte address.
  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] a);
    return TAG_BITS'(a >> (2 + OB + INDEX_BITS));
  endfunction

  // Word-within-line field of a byte address (always zero for 1-word lines).
  function automatic logic [CW-1:0] addr_off(input logic [31:0] a);
    if (OB == 0) begin
      return {CW{1'b0}};
    end else begin
      return CW'(a >> 2);
    end
  endfunction

  // Flat data-array address of a word within a line.
  function automatic logic [AW-1:0] array_addr(input logic [INDEX_BITS-1:0] idx,
                                               input logic [CW-1:0] off);
    if (OB == 0) begin
      return AW'(idx);
    end else begin
      return (AW'(idx) << OB) | AW'(off);
    end
  endfunction

  // Byte-lane merge used for store hits.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  state_t                state_r;
  logic [CW-1:0]         cnt_r;
  logic [LINES-1:0]      valid_r;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [31:0]           mem_addr_r;
  logic [31:0]           mem_wdata_r;
  logic [3:0]            mem_be_r;

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES * LINE_WORDS];

  logic [INDEX_BITS-1:0] req_idx_s;
  logic [TAG_BITS-1:0]   req_tag_s;
  logic [CW-1:0]         req_off_s;
  logic [INDEX_BITS-1:0] cur_idx_s;
  logic [TAG_BITS-1:0]   cur_tag_s;
  logic [CW-1:0]         cur_off_s;
  logic                  hit_s;
  logic                  cur_hit_s;
  logic                  ack_s;
  logic                  last_word_s;
  logic                  stall_s;
  logic [31:0]           rdata_s;

  assign req_idx_s   = addr_index(bus.iAddr);
  assign req_tag_s   = addr_tag(bus.iAddr);
  assign req_off_s   = addr_off(bus.iAddr);
  assign cur_idx_s   = addr_index(mem_addr_r);
  assign cur_tag_s   = addr_tag(mem_addr_r);
  assign cur_off_s   = addr_off(mem_addr_r);
  assign ack_s       = bus.iMemAck && mem_req_r;
  assign last_word_s = (cnt_r == LAST_WORD);

  // Lookup of the incoming request and of the line owned by the pending store.
  always_comb begin
    hit_s     = 1'b0;
    cur_hit_s = 1'b0;
    if (state_r == IDLE) begin
      hit_s = valid_r[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s);
    end else begin
      cur_hit_s = valid_r[cur_idx_s] && (tag_mem[cur_idx_s] == cur_tag_s);
    end
  end

  // Core-facing stall and load data; flush takes priority over a request.
  always_comb begin
    stall_s = 1'b0;
    rdata_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (bus.iReq) begin
          if (bus.iFlush || bus.iWe || !hit_s) begin
            stall_s = 1'b1;
          end else begin
            stall_s = 1'b0;
            rdata_s = data_mem[array_addr(req_idx_s, req_off_s)];
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      REFILL:  stall_s = 1'b1;
      WRITE:   stall_s = !ack_s;
      default: stall_s = 1'b0;
    endcase
  end

  // Control FSM: state, refill counter, valid bits and memory request outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      valid_r     <= {LINES{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.iFlush) begin
            valid_r <= {LINES{1'b0}};
          end else if (bus.iReq && bus.iWe) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= {bus.iAddr[31:2], 2'b00};
            mem_wdata_r <= bus.iWdata;
            mem_be_r    <= bus.iBe;
            state_r     <= WRITE;
          end else if (bus.iReq && !hit_s) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= bus.iAddr & ~LINE_MASK;
            mem_be_r   <= 4'hF;
            cnt_r      <= {CW{1'b0}};
            state_r    <= REFILL;
          end
        end
        REFILL: begin
          if (ack_s) begin
            if (last_word_s) begin
              valid_r[cur_idx_s] <= 1'b1;
              mem_req_r          <= 1'b0;
              cnt_r              <= {CW{1'b0}};
              state_r            <= IDLE;
            end else begin
              cnt_r      <= cnt_r + CW'(1);
              mem_addr_r <= mem_addr_r + 32'd4;
            end
          end
        end
        WRITE: begin
          if (ack_s) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage: refill words land on each ack, store hits merge on the ack.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      if ((state_r == REFILL) && ack_s) begin
        data_mem[array_addr(cur_idx_s, cnt_r)] <= bus.iMemRdata;
        if (last_word_s) begin
          tag_mem[cur_idx_s] <= cur_tag_s;
        end
      end else if ((state_r == WRITE) && ack_s && cur_hit_s) begin
        data_mem[array_addr(cur_idx_s, cur_off_s)] <=
          merge_bytes(data_mem[array_addr(cur_idx_s, cur_off_s)], mem_wdata_r, mem_be_r);
      end
    end
  end

  assign bus.oRdata    = rdata_s;
  assign bus.oStall    = stall_s;
  assign bus.oMemReq   = mem_req_r;
  assign bus.oMemWe    = mem_we_r;
  assign bus.oMemAddr  = mem_addr_r;
  assign bus.oMemWdata = mem_wdata_r;
  assign bus.oMemBe    = mem_be_r;

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 6, SHALL set the number of cache lines to 2**INDEX_BITS (legal range 1..10).
REQ-002 Parameter LINE_WORDS, default 4, SHALL set the number of 32-bit words per line (power of 2, 1..16).
REQ-003 iCLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 iRST  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 iReq  in  1  core access request; held by the core while oStall=1.
REQ-006 iWe  in  1  1 = store, 0 = load.
REQ-007 iAddr  in  32  byte address; bits [1:0] ignored.
REQ-008 iWdata  in  32  store data.
REQ-009 iBe  in  4  store byte enables.
REQ-010 iFlush  in  1  invalidate-all request.
REQ-011 oRdata  out  32  load data.
REQ-012 oStall  out  1  core must hold its request.
REQ-013 oMemReq  out  1  memory request valid.
REQ-014 oMemWe  out  1  memory write.
REQ-015 oMemAddr  out  32  word-aligned memory address.
REQ-016 oMemWdata  out  32  memory write data.
REQ-017 oMemBe  out  4  memory byte enables.
REQ-018 iMemAck  in  1  memory completion; read data valid on iMemRdata in the same cycle.
REQ-019 iMemRdata  in  32  memory read data.

Function
REQ-020 Address split SHALL be: word offset = iAddr[2+OB-1:2] (OB = log2 LINE_WORDS), index = next INDEX_BITS bits, tag = remaining upper bits.
REQ-021 Organisation SHALL be direct-mapped, with a valid bit, tag and LINE_WORDS data words per line; write-through, read-allocate, no write-allocate.
REQ-022 FSM SHALL have exactly three states: IDLE, REFILL, WRITE.
REQ-023 Hit SHALL be valid[index] && tag match, evaluated combinationally in IDLE.
REQ-024 IDLE, iReq && !iWe && hit: oRdata = cached word in the same cycle, oStall=0, no state change.
REQ-025 IDLE, iReq && !iWe && !hit: oStall=1; go to REFILL and capture the line base address.
REQ-026 REFILL SHALL issue LINE_WORDS reads (oMemWe=0, oMemBe=4'hF) at base, base+4, ... in ascending order, using a word counter.
REQ-027 During REFILL, each iMemAck SHALL write iMemRdata into the data array and advance the counter.
REQ-028 On the last ack, REFILL SHALL set valid and tag and return to IDLE; the held request then hits. Miss penalty = 1 + sum of ack latencies + 1 cycles.
REQ-029 IDLE, iReq && iWe: oStall=1; capture addr/data/be; go to WRITE.
REQ-030 WRITE SHALL drive oMemReq=1, oMemWe=1 with the captured address, data and byte enables.
REQ-031 In WRITE, oStall = !iMemAck; on ack, return to IDLE.
REQ-032 Store hit SHALL update the cached word bytes selected by iBe on the ack cycle; a store miss SHALL NOT allocate or modify any line.
REQ-033 oMemReq, oMemAddr, oMemWdata, oMemBe and oMemWe SHALL be stable from assertion until the ack cycle.
REQ-034 iMemAck SHALL be ignored when oMemReq=0; an ack in the first cycle of oMemReq SHALL be legal.
REQ-035 oMemReq SHALL deassert in the cycle after the final ack.
REQ-036 iFlush SHALL be honoured only in IDLE and SHALL clear all valid bits in one cycle.
REQ-037 A simultaneous iFlush and iReq SHALL give iFlush priority: oStall=1 that cycle, and the request is evaluated the next cycle.
REQ-038 iFlush asserted in REFILL or WRITE SHALL be ignored; the core re-asserts it.
REQ-039 iReq=0 SHALL give oStall=0 in IDLE; oRdata is don't-care except on a load hit.

Reset
REQ-040 iRST SHALL, at the next edge from any state (including mid-REFILL or mid-WRITE): set state IDLE, clear all valid bits and counters, and deassert oMemReq/oMemWe.
REQ-041 After iRST the following outputs SHALL be 0: oStall (with iReq=0), oMemAddr, oMemWdata, oMemBe and oRdata.
REQ-042 Data and tag arrays SHALL NOT require reset.

Verification (INDEX_BITS=6, LINE_WORDS=4: index=[9:4], tag=[31:10])
REQ-043 Cold load 0x0000_1004 -> reads at 0x1000, 0x1004, 0x1008, 0x100C in order; after the last ack, oStall=0 and oRdata = word returned for 0x1004.
REQ-044 Store 0x1008, data 0xAABBCCDD, iBe=4'b0011, after the line is filled with 0x11223344 -> one memory write with the same data and enables; a later load of 0x1008 returns 0x1122CCDD with no memory traffic.
REQ-045 Load 0x1000, then load 0x1400 (same index, new tag) -> second refill; a following load of 0x1000 misses again.
REQ-046 Store miss 0x2000 -> a single memory write and no reads; a following load of 0x2000 performs a refill.
REQ-047 iFlush and a load of 0x1000 (cached) in the same cycle -> oStall=1; the next cycle misses and refills.
REQ-048 iRST after 2 of 4 refill acks -> oMemReq=0 next cycle; the line is invalid; a subsequent load of the same address refills all 4 words.
